// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the stack CPU front end.
//   INSN_NOP      - the all-zero instruction that decode treats as a NOP.
//   INSN_PARCELS  - the number of 16-bit parcels in one 48-bit instruction.
//   LAST_BEAT     - the beat index of the final parcel.
//   fetch_state_t - the states of the stage-1 fetch FSM.
//   next_fetch_pc - the PC that follows a 48-bit instruction, with the JS bit kept.
package cpu_pkg;

  localparam int PARCEL_W     = 16;
  localparam int INSN_W       = 48;
  localparam int INSN_PARCELS = 3;

  localparam logic [INSN_W-1:0] INSN_NOP  = 48'h0;
  localparam logic [1:0]        LAST_BEAT = 2'(INSN_PARCELS - 1);

  typedef enum logic [1:0] {
    FETCH = 2'd0,  // requesting parcels, beat 0..2
    FULL  = 2'd1,  // complete instruction waiting for decode
    DRAIN = 2'd2   // redirected with a request still outstanding
  } fetch_state_t;

  // The instruction is 3 halfwords (6 bytes) long. The halfword part wraps
  // modulo 2^31 and bit 0, the JS-mode flag, is carried through unchanged.
  function automatic logic [31:0] next_fetch_pc(input logic [31:0] pc);
    return {pc[31:1] + 31'd3, pc[0]};
  endfunction

endpackage

// File: rtl/fetch_assembler.sv
// fetch_assembler: builds one 48-bit instruction out of three 16-bit parcels.
//
// Ports:
//   clk, rst_b  - clock; asynchronous active-low reset.
//   clear       - discard the partial or complete instruction, beat back to 0.
//                 Takes priority over load.
//   load        - the parcel on `parcel` is accepted this cycle.
//   parcel      - 16-bit parcel data.
//   beat        - index of the parcel the next load writes (0..2).
//   full        - all three parcels are present; further loads are ignored
//                 until clear.
//   insn        - assembled instruction. Parcel 0 sits in [47:32], parcel 1 in
//                 [31:16] and parcel 2 in [15:0].
//
// The buffer shifts left by one parcel on each load. After three loads the
// first parcel has reached the top field, so no per-beat insert mux is needed.
module fetch_assembler
  import cpu_pkg::*;
(
  input  logic                clk,
  input  logic                rst_b,
  input  logic                clear,
  input  logic                load,
  input  logic [PARCEL_W-1:0] parcel,
  output logic [1:0]          beat,
  output logic                full,
  output logic [INSN_W-1:0]   insn
);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      beat <= 2'd0;
      full <= 1'b0;
      insn <= INSN_NOP;
    end else if (clear) begin
      beat <= 2'd0;
      full <= 1'b0;
      insn <= INSN_NOP;
    end else if (load && !full) begin
      insn <= {insn[INSN_W-PARCEL_W-1:0], parcel};
      if (beat == LAST_BEAT) begin
        beat <= 2'd0;
        full <= 1'b1;
      end else begin
        beat <= beat + 2'd1;
      end
    end
  end

endmodule

// File: rtl/cpu_fetch.sv
// cpu_fetch: stage-1 instruction fetch unit of the stack CPU.
//
// Fetches three 16-bit parcels per instruction from instruction memory,
// assembles them into a 48-bit instruction and hands it to decode together
// with its PC. Decode can stall the stage. Execute can redirect fetch to a
// new PC.
//
// Ports:
//   RESET_PC        - PC after reset. Bit 0 is the JS-mode flag.
//   clk, rst_b      - clock; asynchronous active-low reset.
//   im__req         - parcel request, registered.
//   im__addr        - halfword address of the requested parcel, registered.
//   im__ack         - memory accepted the request; im__rdata valid now.
//   im__rdata       - parcel data.
//   stall_2a        - decode cannot accept; stage-1 outputs hold.
//   fe__redirect    - one-cycle pulse: flush and restart at fe__target.
//   fe__target      - redirect PC, bit 0 included.
//   instruction_1a  - instruction to decode; INSN_NOP when none is valid.
//   pc_1a           - PC of instruction_1a.
//   fetch_state     - current FSM state, for observation only.
//
// Memory handshake: a parcel transfers in any cycle where im__req and im__ack
// are both high, and im__rdata is taken in that same cycle. While im__req is
// high and im__ack is low, im__addr does not change and im__req stays high.
// Memory may ack in the first cycle of a request (zero wait). The only way
// im__req drops without an ack is reset.
module cpu_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                clk,
  input  logic                rst_b,
  output logic                im__req,
  output logic [30:0]         im__addr,
  input  logic                im__ack,
  input  logic [PARCEL_W-1:0] im__rdata,
  input  logic                stall_2a,
  input  logic                fe__redirect,
  input  logic [31:0]         fe__target,
  output logic [INSN_W-1:0]   instruction_1a,
  output logic [31:0]         pc_1a,
  output fetch_state_t        fetch_state
);

  fetch_state_t        state;
  logic [31:0]         fpc;
  logic                accept;
  logic                asm_clear;
  logic                asm_load;
  logic [1:0]          asm_beat;
  logic                asm_full;
  logic [INSN_W-1:0]   asm_insn;
  logic [31:0]         fpc_next;

  assign fetch_state = state;
  assign accept      = im__req && im__ack;
  assign fpc_next    = next_fetch_pc(fpc);

  // The buffer empties on a redirect and whenever a complete instruction
  // moves to the output registers. Only acks seen in FETCH are parcels of the
  // current instruction. An ack in the redirect cycle or in DRAIN belongs to
  // the old path and is dropped.
  always_comb begin
    asm_clear = 1'b0;
    asm_load  = 1'b0;
    if (fe__redirect) begin
      asm_clear = 1'b1;
    end else if (state == FULL && !stall_2a) begin
      asm_clear = 1'b1;
    end else if (state == FETCH && accept) begin
      asm_load = 1'b1;
    end
  end

  fetch_assembler u_asm (
    .clk    (clk),
    .rst_b  (rst_b),
    .clear  (asm_clear),
    .load   (asm_load),
    .parcel (im__rdata),
    .beat   (asm_beat),
    .full   (asm_full),
    .insn   (asm_insn)
  );

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state          <= FETCH;
      fpc            <= RESET_PC;
      im__req        <= 1'b0;
      im__addr       <= RESET_PC[31:1];
      instruction_1a <= INSN_NOP;
      pc_1a          <= RESET_PC;
    end else if (fe__redirect) begin
      // The redirect overrides the stall so that a wrong-path instruction
      // held in the outputs never reaches decode.
      fpc            <= fe__target;
      instruction_1a <= INSN_NOP;
      if (im__req && !im__ack) begin
        // The request cannot be withdrawn. Keep it up at the old address
        // until memory acks it, then start on the target.
        state <= DRAIN;
      end else begin
        state    <= FETCH;
        im__req  <= 1'b1;
        im__addr <= fe__target[31:1];
      end
    end else begin
      if (!stall_2a) begin
        if (asm_full) begin
          instruction_1a <= asm_insn;
          pc_1a          <= fpc;
        end else begin
          instruction_1a <= INSN_NOP;
        end
      end

      case (state)
        FETCH: begin
          if (accept) begin
            if (asm_beat == LAST_BEAT) begin
              state   <= FULL;
              im__req <= 1'b0;
            end else begin
              im__addr <= im__addr + 31'd1;
            end
          end else begin
            // Also raises the first request after reset.
            im__req <= 1'b1;
          end
        end

        FULL: begin
          if (!stall_2a) begin
            state    <= FETCH;
            fpc      <= fpc_next;
            im__req  <= 1'b1;
            im__addr <= fpc_next[31:1];
          end
        end

        DRAIN: begin
          // fpc already holds the newest target. The acked data is stale.
          if (accept) begin
            state    <= FETCH;
            im__addr <= fpc[31:1];
          end
        end

        default: begin
          state   <= FETCH;
          im__req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_fetch.sv
// tb_cpu_fetch: self-checking bench for cpu_fetch.
//
// A memory model with programmable ack latency answers the DUT's requests.
// The reference model works at the transaction level. Each expected
// delivery is a {pc, instruction} pair, where the instruction is the three
// memory words at pc/2 .. pc/2+2 and the following pc is pc+6. A redirect
// restarts the expected stream at the target. Directed sections follow the
// test plan, then a randomized section mixes latency, stalls and redirects.
module tb_cpu_fetch;
  import cpu_pkg::*;

  localparam logic [31:0] RST_PC = 32'h100;

  logic                clk = 1'b0;
  logic                rst_b;
  logic                im__req;
  logic [30:0]         im__addr;
  logic                im__ack;
  logic [15:0]         im__rdata;
  logic                stall_2a;
  logic                fe__redirect;
  logic [31:0]         fe__target;
  logic [47:0]         instruction_1a;
  logic [31:0]         pc_1a;
  fetch_state_t        dbg_state;

  // clock / reset
  always #5 clk = ~clk;

  cpu_fetch #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst_b          (rst_b),
    .im__req        (im__req),
    .im__addr       (im__addr),
    .im__ack        (im__ack),
    .im__rdata      (im__rdata),
    .stall_2a       (stall_2a),
    .fe__redirect   (fe__redirect),
    .fe__target     (fe__target),
    .instruction_1a (instruction_1a),
    .pc_1a          (pc_1a),
    .fetch_state    (dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
    end
  endtask

  // reference model
  function automatic logic [15:0] mem_word(input logic [30:0] a);
    case (a)
      31'h80:  return 16'hA1B2;
      31'h81:  return 16'hC3D4;
      31'h82:  return 16'hE5F6;
      default: return 16'h8000 | (a[15:0] ^ {1'b0, a[30:16]} ^ 16'h35C9);
    endcase
  endfunction

  function automatic logic [47:0] ref_insn(input logic [31:0] pc);
    logic [30:0] a;
    a = pc[31:1];
    return {mem_word(a), mem_word(a + 31'd1), mem_word(a + 31'd2)};
  endfunction

  // scoreboard: the next expected {pc, instruction}
  logic [79:0] exp_q[$];

  // bench state
  int          cfg_min_lat = 0, cfg_max_lat = 0, cfg_stall_pct = 0, cfg_redir_pct = 0;
  logic        d_stall = 1'b0, d_redir = 1'b0;
  logic [31:0] d_target = 32'h0;
  logic        arm_valid = 1'b0, arm_fired = 1'b0;
  logic [30:0] arm_addr = 31'h0;
  logic [31:0] arm_target = 32'h0;
  logic        hold_after_del = 1'b0;
  int          mem_cnt = 0, mem_lat = 0;
  int          idle = 0, del_count = 0;
  logic [31:0] last_del_pc = 32'h0;

  logic        prev_redir = 1'b0, prev_stall = 1'b0, prev_req = 1'b0, prev_ack = 1'b0;
  logic [31:0] prev_target = 32'h0, prev_pc = RST_PC;
  logic [30:0] prev_addr = 31'h0;
  logic [47:0] prev_insn = 48'h0;

  // One cycle: check the results of the edge just passed against the model,
  // then drive this cycle's inputs.
  task automatic cycle();
    logic [79:0] e;
    logic [31:0] npc;
    logic        ack, stall, redir;
    logic [31:0] target;
    @(negedge clk);
    if (prev_req && !prev_ack) begin
      check_eq("req_held", im__req, 1);
      check_eq("addr_stable", im__addr, prev_addr);
    end
    if (prev_redir) begin
      check_eq("redirect_nop", instruction_1a, 48'h0);
      check_eq("redirect_pc_hold", pc_1a, prev_pc);
      exp_q.delete();
      exp_q.push_back({prev_target, ref_insn(prev_target)});
      idle = 0;
    end else if (prev_stall) begin
      check_eq("stall_insn_hold", instruction_1a, prev_insn);
      check_eq("stall_pc_hold", pc_1a, prev_pc);
    end else if (instruction_1a != 48'h0) begin
      e = exp_q.pop_front();
      check_eq("deliver_pc", pc_1a, e[79:48]);
      check_eq("deliver_insn", instruction_1a, e[47:0]);
      npc = e[79:48] + 32'd6;
      exp_q.push_back({npc, ref_insn(npc)});
      last_del_pc = pc_1a;
      del_count++;
      idle = 0;
      if (hold_after_del) d_stall = 1'b1;
    end else begin
      check_eq("nop_pc_hold", pc_1a, prev_pc);
    end
    idle++;
    if (idle > 150) begin
      check_eq("progress_idle_cycles", idle, 150);
      idle = 0;
    end
    prev_insn = instruction_1a;
    prev_pc   = pc_1a;
    prev_req  = im__req;
    prev_addr = im__addr;

    // memory driver
    if (im__req) begin
      ack = (mem_cnt >= mem_lat);
      if (ack) begin
        mem_cnt = 0;
        mem_lat = $urandom_range(cfg_max_lat, cfg_min_lat);
      end else begin
        mem_cnt++;
      end
    end else begin
      ack = 1'b0;
      mem_cnt = 0;
    end
    im__ack   = ack;
    im__rdata = ack ? mem_word(im__addr) : 16'($urandom);

    stall  = d_stall || ($urandom_range(99, 0) < cfg_stall_pct);
    redir  = 1'b0;
    target = 32'h0;
    if (arm_valid && im__req && im__addr == arm_addr && !ack) begin
      redir = 1'b1;
      target = arm_target;
      arm_valid = 1'b0;
      arm_fired = 1'b1;
    end else if (d_redir) begin
      redir = 1'b1;
      target = d_target;
    end else if ($urandom_range(99, 0) < cfg_redir_pct) begin
      redir = 1'b1;
      target = $urandom;
    end
    stall_2a     = stall;
    fe__redirect = redir;
    fe__target   = target;
    prev_ack     = ack;
    prev_stall   = stall;
    prev_redir   = redir;
    prev_target  = target;
  endtask

  task automatic pulse_redirect(input logic [31:0] t);
    d_redir = 1'b1;
    d_target = t;
    cycle();
    d_redir = 1'b0;
  endtask

  initial begin
    int start;
    int n;
    rst_b = 1'b0;
    im__ack = 1'b0;
    im__rdata = 16'h0;
    stall_2a = 1'b0;
    fe__redirect = 1'b0;
    fe__target = 32'h0;
    exp_q.push_back({RST_PC, ref_insn(RST_PC)});
    repeat (2) @(negedge clk);
    check_eq("reset_insn", instruction_1a, 48'h0);
    check_eq("reset_pc", pc_1a, RST_PC);
    check_eq("reset_req", im__req, 0);
    check_eq("reset_addr", im__addr, 31'h80);
    rst_b = 1'b1;

    // zero-wait first fetch
    cycle(); check_eq("c1_req", im__req, 1); check_eq("c1_addr", im__addr, 31'h80);
    cycle(); check_eq("c2_addr", im__addr, 31'h81);
    cycle(); check_eq("c3_addr", im__addr, 31'h82);
    cycle(); check_eq("c4_req_low", im__req, 0);
    cycle();
    check_eq("c5_insn", instruction_1a, 48'hA1B2C3D4E5F6);
    check_eq("c5_pc", pc_1a, 32'h100);
    check_eq("c5_next_addr", im__addr, 31'h83);
    check_eq("c5_req", im__req, 1);
    cycle(); cycle();

    // stall for 6 cycles while FULL
    d_stall = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      check_eq("stall_no_req", im__req, 0);
      check_eq("stall_frozen_pc", pc_1a, 32'h100);
    end
    d_stall = 1'b0;
    cycle();
    check_eq("stall_end_no_req", im__req, 0);
    cycle();
    check_eq("release_pc", pc_1a, 32'h106);
    check_eq("release_insn", instruction_1a, ref_insn(32'h106));
    check_eq("release_addr", im__addr, 31'h86);

    // 3-cycle ack latency
    cfg_min_lat = 3; cfg_max_lat = 3;
    start = del_count;
    n = 0;
    while (del_count - start < 2 && n < 100) begin cycle(); n++; end
    check_eq("lat3_deliveries", del_count - start, 2);

    // redirect while beat 1 is pending
    cfg_min_lat = 5; cfg_max_lat = 5;
    pulse_redirect(32'h300);
    arm_addr = 31'h181; arm_target = 32'h201; arm_fired = 1'b0; arm_valid = 1'b1;
    n = 0;
    while (!arm_fired && n < 100) begin cycle(); n++; end
    check_eq("drain_armed", arm_fired, 1);
    cycle();
    check_eq("drain_req", im__req, 1);
    check_eq("drain_old_addr", im__addr, 31'h181);
    n = 0;
    while (im__addr == 31'h181 && n < 30) begin cycle(); n++; end
    check_eq("drain_restart_addr", im__addr, 31'h100);
    check_eq("drain_restart_req", im__req, 1);
    start = del_count;
    n = 0;
    while (del_count == start && n < 100) begin cycle(); n++; end
    check_eq("drain_deliver_pc", last_del_pc, 32'h201);

    // redirect while an instruction is held under stall
    cfg_min_lat = 0; cfg_max_lat = 0;
    hold_after_del = 1'b1;
    start = del_count;
    n = 0;
    while (del_count == start && n < 100) begin cycle(); n++; end
    hold_after_del = 1'b0;
    check_eq("held_insn_valid", instruction_1a != 48'h0, 1);
    cycle();
    check_eq("held_insn_still", instruction_1a != 48'h0, 1);
    pulse_redirect(32'h400);
    cycle();
    check_eq("flush_under_stall", instruction_1a, 48'h0);
    d_stall = 1'b0;
    cycle(); cycle();

    // halfword address wrap
    pulse_redirect(32'hFFFFFFFC);
    cycle(); check_eq("wrap_a0", im__addr, 31'h7FFFFFFE);
    cycle(); check_eq("wrap_a1", im__addr, 31'h7FFFFFFF);
    cycle(); check_eq("wrap_a2", im__addr, 31'h0);
    cycle(); check_eq("wrap_full_req", im__req, 0);
    cycle();
    check_eq("wrap_pc", pc_1a, 32'hFFFFFFFC);
    check_eq("wrap_next_addr", im__addr, 31'h1);

    // randomized traffic
    cfg_min_lat = 0; cfg_max_lat = 3;
    cfg_stall_pct = 25; cfg_redir_pct = 3;
    start = del_count;
    for (int i = 0; i < 3000; i++) cycle();
    cfg_stall_pct = 0; cfg_redir_pct = 0;
    for (int i = 0; i < 40; i++) cycle();
    check_eq("random_made_progress", (del_count - start) > 100, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
